// File: rtl/vdec_hs_pkg.sv
// Shared HS-SCCH/HS-DSCH decode definitions: selector FSM states and symbol/SER constants.
package vdec_hs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CMP    = 3'd3,
        ST_FINISH = 3'd4
    } vdec_hs_sel_st_t;

    localparam int         HS_PART1_SYS = 40;
    localparam logic [6:0] SER_MAX      = 7'h7F;
    localparam int         HS_MAX_CAND  = 4;
    localparam int         HS_TMO_CYC   = 255;

endpackage

// File: rtl/vdec_hs_scch_sel_if.sv
// Control/result and SER-engine handshake bundle of the HS-SCCH candidate selector.
// det_tmo exists only when VDEC_HS_SCCH_SEL_TMO_EN is defined.
interface vdec_hs_scch_sel_if;
    logic       start;
    logic [2:0] cand_num;
    logic [9:0] base_sys;
    logic [6:0] ser_thr;
    logic       busy;
    logic       done;
    logic       det_valid;
    logic [1:0] det_idx;
    logic [6:0] det_ser;
    logic [1:0] cand_idx;
    logic       ser_start;
    logic [9:0] ser_base_sys;
    logic       ser_done;
    logic [6:0] ser_acc;
`ifdef VDEC_HS_SCCH_SEL_TMO_EN
    logic       det_tmo;

    modport slave (
        input  start, cand_num, base_sys, ser_thr, ser_done, ser_acc,
        output busy, done, det_valid, det_idx, det_ser, cand_idx,
               ser_start, ser_base_sys, det_tmo
    );
    modport master (
        output start, cand_num, base_sys, ser_thr, ser_done, ser_acc,
        input  busy, done, det_valid, det_idx, det_ser, cand_idx,
               ser_start, ser_base_sys, det_tmo
    );
`else
    modport slave (
        input  start, cand_num, base_sys, ser_thr, ser_done, ser_acc,
        output busy, done, det_valid, det_idx, det_ser, cand_idx,
               ser_start, ser_base_sys
    );
    modport master (
        output start, cand_num, base_sys, ser_thr, ser_done, ser_acc,
        input  busy, done, det_valid, det_idx, det_ser, cand_idx,
               ser_start, ser_base_sys
    );
`endif
endinterface

// File: rtl/vdec_hs_scch_sel.sv
// HS-SCCH part1 selector: runs the SER engine once per candidate, keeps the lowest SER, applies ser_thr.
// Macro VDEC_HS_SCCH_SEL_TMO_EN adds a per-candidate WAIT watchdog and the det_tmo flag.
module vdec_hs_scch_sel
    import vdec_hs_pkg::*;
#(
    parameter int         MAX_CAND   = HS_MAX_CAND,
    parameter logic [9:0] SYS_STRIDE = 10'(HS_PART1_SYS)
`ifdef VDEC_HS_SCCH_SEL_TMO_EN
    ,
    parameter int         TMO_CYC    = HS_TMO_CYC
`endif
) (
    input  logic              clk,
    input  logic              rst,
    vdec_hs_scch_sel_if.slave sel
);

    localparam logic [2:0] MAX_C3 = 3'(MAX_CAND);

    vdec_hs_sel_st_t r_state;
    vdec_hs_sel_st_t w_next;

    logic [1:0] r_last;
    logic [6:0] r_thr;
    logic [1:0] r_cand_idx;
    logic [9:0] r_sys;
    logic [6:0] r_cur;
    logic [6:0] r_min;
    logic [1:0] r_min_idx;
    logic       r_det_valid;
    logic [1:0] r_det_idx;
    logic [6:0] r_det_ser;

    logic [2:0] w_num;
    logic [1:0] w_last_idx;
    logic       w_lt;
    logic [6:0] w_new_min;
    logic [1:0] w_new_idx;
    logic       w_is_last;
    logic       w_ser_start;
    logic       w_done;
    logic       w_tmo;

`ifdef VDEC_HS_SCCH_SEL_TMO_EN
    logic [7:0] r_wdog;
    logic       r_det_tmo;

    assign w_tmo       = (r_wdog == 8'(TMO_CYC - 1)) && !sel.ser_done;
    assign sel.det_tmo = r_det_tmo;
`else
    assign w_tmo = 1'b0;
`endif

    // cand_num 0 behaves as 1, anything above MAX_CAND is clamped
    always_comb begin
        w_num = sel.cand_num;
        if (sel.cand_num == 3'd0) begin
            w_num = 3'd1;
        end else if (sel.cand_num > MAX_C3) begin
            w_num = MAX_C3;
        end
    end
    assign w_last_idx = 2'(w_num - 3'd1);

    // Strict compare so ties keep the earlier (lower) candidate
    assign w_lt      = (r_cur < r_min);
    assign w_new_min = w_lt ? r_cur      : r_min;
    assign w_new_idx = w_lt ? r_cand_idx : r_min_idx;
    assign w_is_last = (r_cand_idx == r_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ser_start = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sel.start) begin
                    w_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_ser_start = 1'b1;
                w_next      = ST_WAIT;
            end
            ST_WAIT: begin
                if (sel.ser_done) begin
                    w_next = ST_CMP;
                end else if (w_tmo) begin
                    w_next = ST_FINISH;
                end
            end
            ST_CMP: begin
                w_next = w_is_last ? ST_FINISH : ST_LAUNCH;
            end
            ST_FINISH: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= 2'd0;
            r_thr       <= 7'd0;
            r_cand_idx  <= 2'd0;
            r_sys       <= 10'd0;
            r_cur       <= 7'd0;
            r_min       <= SER_MAX;
            r_min_idx   <= 2'd0;
            r_det_valid <= 1'b0;
            r_det_idx   <= 2'd0;
            r_det_ser   <= 7'd0;
`ifdef VDEC_HS_SCCH_SEL_TMO_EN
            r_wdog      <= 8'd0;
            r_det_tmo   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sel.start) begin
                        r_last      <= w_last_idx;
                        r_thr       <= sel.ser_thr;
                        r_sys       <= sel.base_sys;
                        r_cand_idx  <= 2'd0;
                        r_min       <= SER_MAX;
                        r_min_idx   <= 2'd0;
                        r_det_valid <= 1'b0;
                        r_det_idx   <= 2'd0;
                        r_det_ser   <= 7'd0;
`ifdef VDEC_HS_SCCH_SEL_TMO_EN
                        r_det_tmo   <= 1'b0;
`endif
                    end
                end
                ST_LAUNCH: begin
`ifdef VDEC_HS_SCCH_SEL_TMO_EN
                    r_wdog <= 8'd0;
`endif
                end
                ST_WAIT: begin
                    if (sel.ser_done) begin
                        r_cur <= sel.ser_acc;
                    end
`ifdef VDEC_HS_SCCH_SEL_TMO_EN
                    else if (w_tmo) begin
                        r_det_tmo   <= 1'b1;
                        r_det_valid <= 1'b0;
                        r_det_idx   <= r_min_idx;
                        r_det_ser   <= r_min;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
`endif
                end
                ST_CMP: begin
                    r_min     <= w_new_min;
                    r_min_idx <= w_new_idx;
                    // Results are registered on the way into FINISH so they are valid with done
                    if (w_is_last) begin
                        r_det_idx   <= w_new_idx;
                        r_det_ser   <= w_new_min;
                        r_det_valid <= (w_new_min <= r_thr);
                    end else begin
                        r_cand_idx <= r_cand_idx + 2'd1;
                        r_sys      <= r_sys + SYS_STRIDE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sel.busy         = sel.start | (r_state != ST_IDLE);
    assign sel.done         = w_done;
    assign sel.ser_start    = w_ser_start;
    assign sel.ser_base_sys = r_sys;
    assign sel.cand_idx     = r_cand_idx;
    assign sel.det_valid    = r_det_valid;
    assign sel.det_idx      = r_det_idx;
    assign sel.det_ser      = r_det_ser;

endmodule
